uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter: HEADER_BYTE, 8'hAA, frame start marker.
REQ-002 Parameter: TIMEOUT_CNT, 32'd50_000, maximum clk_in cycles allowed between two consecutive bytes of one frame (1 ms at 50 MHz).
REQ-003 Port: clk_in  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port: rst_in  input  1  reset, asynchronous and active-high.
REQ-005 Port: uart_rx_data  input  8  received byte, valid only in the cycle uart_rx_done is high.
REQ-006 Port: uart_rx_done  input  1  one-cycle strobe marking a new received byte.
REQ-007 Port: cmd_addr  output  8  register address of the last good frame.
REQ-008 Port: cmd_data  output  16  register data of the last good frame, {data_hi, data_lo}.
REQ-009 Port: cmd_valid  output  1  one-cycle pulse; cmd_addr/cmd_data updated in the same cycle.
REQ-010 Port: frame_err  output  1  one-cycle pulse on an aborted frame (timeout or checksum).
REQ-011 Port: cmd_busy  output  1  high whenever the state machine is not IDLE.

Function
REQ-012 Frame byte order SHALL be: HEADER_BYTE, addr, data_hi, data_lo, then chk if REQ-028 applies.
REQ-013 States SHALL be IDLE, ADDR, DATA_H, DATA_L, CHK; a byte is consumed only in a cycle with uart_rx_done high.
REQ-014 IDLE: header byte -> ADDR; any other byte is discarded silently, with no pulse.
REQ-015 ADDR -> DATA_H -> DATA_L: each state stores its byte into a shadow register and advances one state.
REQ-016 A byte equal to HEADER_BYTE inside a frame SHALL be treated as data; there is no mid-frame resync.
REQ-017 On frame completion, cmd_valid SHALL pulse and cmd_addr/cmd_data SHALL update on the clock edge after the final byte's uart_rx_done cycle (latency 1 cycle); the state returns to IDLE on that same edge.
REQ-018 cmd_addr/cmd_data SHALL hold their value until the next good frame; bad frames never modify them.
REQ-019 Inter-byte timer: cleared in IDLE and on every accepted byte; incremented each cycle while not IDLE.
REQ-020 When the timer reaches TIMEOUT_CNT outside IDLE: frame_err pulses for one cycle, the state goes to IDLE, and the partial frame is dropped.
REQ-021 If uart_rx_done and timeout expiry coincide, the byte SHALL win: it is accepted, the timer clears, and frame_err does not pulse.
REQ-022 cmd_valid and frame_err SHALL never be high in the same cycle.
REQ-023 Back-to-back frames SHALL be accepted with uart_rx_done in consecutive cycles; no bytes are lost.
REQ-024 cmd_busy SHALL be combinationally derived from state != IDLE.

Reset
REQ-025 While rst_in is high: state = IDLE, timer = 0, shadow registers = 0, cmd_addr = 0, cmd_data = 0, cmd_valid = 0, frame_err = 0, cmd_busy = 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame and produce no pulse.
REQ-027 After rst_in deasserts, the first uart_rx_done SHALL be processed normally from IDLE.

Configuration
REQ-028 Macro UART_CMD_CHKSUM_EN defined: frames SHALL be 5 bytes. DATA_L -> CHK. In CHK, if chk == (addr + data_hi + data_lo) mod 256, cmd_valid pulses; otherwise frame_err pulses. Both cases return to IDLE.
REQ-029 Macro UART_CMD_CHKSUM_EN undefined: frames SHALL be 4 bytes. CHK state and checksum logic are absent, and the frame completes in DATA_L; frame_err arises only from timeout.

Verification
REQ-030 Good frame (checksum off): AA 12 34 56 -> one cmd_valid, cmd_addr = 8'h12, cmd_data = 16'h3456, one cycle after the 4th done.
REQ-031 Checksum on: AA 01 02 03 06 -> cmd_valid with 01/0203; AA 01 02 03 07 -> frame_err only, and outputs keep their prior values.
REQ-032 Garbage then frame: 00 FF AA 10 AA 20 (plus chk 0xDA if enabled) -> no pulse for the leading bytes; cmd_addr = 8'h10, cmd_data = 16'hAA20.
REQ-033 Timeout, TIMEOUT_CNT = 100: AA 05, then idle for 100 cycles -> one frame_err and cmd_busy low. Repeat with the 3rd done landing exactly on the expiry cycle -> no frame_err, and the frame still in progress.
REQ-034 Reset mid-frame: AA 07, rst_in pulse, then 11 22 -> no pulses, outputs zero. A following full frame decodes correctly.
REQ-035 Back-to-back: two frames with done strobes every cycle -> two cmd_valid pulses with the correct values.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Decodes HEADER/addr/data_hi/data_lo byte frames from a UART receiver into register-write commands.
// Define UART_CMD_CHKSUM_EN to add a trailing checksum byte (addr + data_hi + data_lo mod 256).
module uart_cmd_decoder #(
    parameter logic [7:0]  HEADER_BYTE = 8'hAA,
    parameter logic [31:0] TIMEOUT_CNT = 32'd50_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_done,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        cmd_busy
);

    localparam int unsigned TIMER_W = 32;

`ifdef UART_CMD_CHKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_DATA_H = 3'd2,
        S_DATA_L = 3'd3,
        S_CHK    = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADDR   = 2'd1,
        S_DATA_H = 2'd2,
        S_DATA_L = 2'd3
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TIMER_W-1:0]   r_timer;
    logic [TIMER_W-1:0]   w_timer_nxt;
    logic [TIMER_W-1:0]   w_timer_inc;
    logic                 w_expire;
    logic [7:0]           r_addr;
    logic [7:0]           w_addr_nxt;
    logic [7:0]           r_data_hi;
    logic [7:0]           w_data_hi_nxt;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]           r_data_lo;
    logic [7:0]           w_data_lo_nxt;
    logic [7:0]           w_chk_sum;
`endif
    logic [7:0]           r_cmd_addr;
    logic [7:0]           w_cmd_addr_nxt;
    logic [15:0]          r_cmd_data;
    logic [15:0]          w_cmd_data_nxt;
    logic                 r_cmd_valid;
    logic                 w_cmd_valid_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;

    // Expiry fires in the cycle the timer would advance to TIMEOUT_CNT; a byte in that cycle wins.
    assign w_timer_inc = r_timer + TIMER_W'(1);
    assign w_expire    = (r_state != S_IDLE) && !uart_rx_done && (w_timer_inc >= TIMEOUT_CNT);

`ifdef UART_CMD_CHKSUM_EN
    assign w_chk_sum = r_addr + r_data_hi + r_data_lo;
`endif

    // Next-state, shadow capture and output pulse generation
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_data_hi_nxt   = r_data_hi;
`ifdef UART_CMD_CHKSUM_EN
        w_data_lo_nxt   = r_data_lo;
`endif
        w_cmd_addr_nxt  = r_cmd_addr;
        w_cmd_data_nxt  = r_cmd_data;
        w_cmd_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;

        if ((r_state == S_IDLE) || uart_rx_done || w_expire) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = w_timer_inc;
        end

        case (r_state)
            S_IDLE: begin
                if (uart_rx_done && (uart_rx_data == HEADER_BYTE)) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (uart_rx_done) begin
                    w_addr_nxt  = uart_rx_data;
                    w_state_nxt = S_DATA_H;
                end
            end
            S_DATA_H: begin
                if (uart_rx_done) begin
                    w_data_hi_nxt = uart_rx_data;
                    w_state_nxt   = S_DATA_L;
                end
            end
            S_DATA_L: begin
                if (uart_rx_done) begin
`ifdef UART_CMD_CHKSUM_EN
                    w_data_lo_nxt   = uart_rx_data;
                    w_state_nxt     = S_CHK;
`else
                    w_cmd_addr_nxt  = r_addr;
                    w_cmd_data_nxt  = {r_data_hi, uart_rx_data};
                    w_cmd_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
`endif
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            S_CHK: begin
                if (uart_rx_done) begin
                    if (uart_rx_data == w_chk_sum) begin
                        w_cmd_addr_nxt  = r_addr;
                        w_cmd_data_nxt  = {r_data_hi, r_data_lo};
                        w_cmd_valid_nxt = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_expire) begin
            w_state_nxt     = S_IDLE;
            w_frame_err_nxt = 1'b1;
        end
    end

    // State, timer, shadow and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_addr      <= '0;
            r_data_hi   <= '0;
`ifdef UART_CMD_CHKSUM_EN
            r_data_lo   <= '0;
`endif
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_addr      <= w_addr_nxt;
            r_data_hi   <= w_data_hi_nxt;
`ifdef UART_CMD_CHKSUM_EN
            r_data_lo   <= w_data_lo_nxt;
`endif
            r_cmd_addr  <= w_cmd_addr_nxt;
            r_cmd_data  <= w_cmd_data_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign cmd_addr  = r_cmd_addr;
    assign cmd_data  = r_cmd_data;
    assign cmd_valid = r_cmd_valid;
    assign frame_err = r_frame_err;
    assign cmd_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios plus randomized byte streams
// checked against a frame-level queue model.
module tb_uart_cmd_decoder;

    localparam logic [7:0]  HDR = 8'hAA;
    localparam int unsigned T   = 100;
`ifdef UART_CMD_CHKSUM_EN
    localparam int unsigned PAYLOAD = 4;
`else
    localparam int unsigned PAYLOAD = 3;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_done = 1'b0;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        frame_err;
    logic        cmd_busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_cmd_decoder #(
        .HEADER_BYTE (HDR),
        .TIMEOUT_CNT (32'd100)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .uart_rx_data (uart_rx_data),
        .uart_rx_done (uart_rx_done),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .frame_err    (frame_err),
        .cmd_busy     (cmd_busy)
    );

    always #5 clk_in = ~clk_in;

    // Pulse monitor
    int          obs_valid_n = 0;
    int          obs_err_n   = 0;
    int          obs_both    = 0;
    logic [23:0] obs_q[$];

    always @(posedge clk_in) begin
        #1;
        if (cmd_valid === 1'b1) begin
            obs_valid_n++;
            obs_q.push_back({cmd_addr, cmd_data});
        end
        if (frame_err === 1'b1) obs_err_n++;
        if (cmd_valid === 1'b1 && frame_err === 1'b1) obs_both++;
    end

    // Frame-level reference model
    logic [7:0]  m_frame[$];
    bit          m_in = 1'b0;
    int          m_gap = 0;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_data = 16'h0000;
    int          m_valid_n = 0;
    int          m_err_n = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  fq[$];

    function automatic logic [7:0] chk(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
        int s;
        s = int'(a) + int'(h) + int'(l);
        return 8'(s % 256);
    endfunction

    function automatic void model_reset();
        m_in = 1'b0;
        m_frame.delete();
        m_gap = 0;
        m_addr = 8'h00;
        m_data = 16'h0000;
    endfunction

    function automatic void model_done(input logic [7:0] b);
        bit good;
        m_gap = 0;
        if (!m_in) begin
            m_frame.delete();
            if (b == HDR) m_in = 1'b1;
            return;
        end
        m_frame.push_back(b);
        if (m_frame.size() == int'(PAYLOAD)) begin
            good = 1'b1;
            if (PAYLOAD == 4) good = (chk(m_frame[0], m_frame[1], m_frame[2]) == m_frame[3]);
            if (good) begin
                m_addr = m_frame[0];
                m_data = {m_frame[1], m_frame[2]};
                m_valid_n++;
                exp_q.push_back({m_addr, m_data});
            end else begin
                m_err_n++;
            end
            m_in = 1'b0;
            m_frame.delete();
        end
    endfunction

    function automatic void model_idle();
        m_gap++;
        if (m_in && m_gap == int'(T)) begin
            m_err_n++;
            m_in = 1'b0;
            m_frame.delete();
        end
    endfunction

    // One clock cycle of stimulus; called and returns at a falling edge.
    task automatic cyc(input logic d, input logic [7:0] b);
        uart_rx_done = d;
        uart_rx_data = b;
        if (rst_in) model_reset();
        else if (d) model_done(b);
        else model_idle();
        @(negedge clk_in);
        uart_rx_done = 1'b0;
    endtask

    task automatic mk_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        fq.delete();
        fq.push_back(HDR);
        fq.push_back(a);
        fq.push_back(h);
        fq.push_back(l);
        if (PAYLOAD == 4) fq.push_back(c);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        cyc(1'b0, 8'h00);
        cyc(1'b1, HDR);
        n_tests++; if (cmd_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h exp 00", cmd_addr); end
        n_tests++; if (cmd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h exp 0000", cmd_data); end
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", cmd_valid); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", frame_err); end
        n_tests++; if (cmd_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", cmd_busy); end
        rst_in = 1'b0;
        cyc(1'b0, 8'h00);
    endtask

    task automatic test_good_frame();
        int v0 = obs_valid_n;
        mk_frame(8'h12, 8'h34, 8'h56, 8'h9C);
        foreach (fq[i]) begin
            cyc(1'b1, fq[i]);
            if (i == fq.size() - 2) begin
                n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL good_early: valid got %b exp 0", cmd_valid); end
            end
        end
        n_tests++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL good_latency: valid got %b exp 1", cmd_valid); end
        n_tests++; if (cmd_addr !== 8'h12) begin n_fail++; $display("FAIL good_addr: got %h exp 12", cmd_addr); end
        n_tests++; if (cmd_data !== 16'h3456) begin n_fail++; $display("FAIL good_data: got %h exp 3456", cmd_data); end
        n_tests++; if (cmd_busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b exp 0", cmd_busy); end
        cyc(1'b0, 8'h00);
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width: valid got %b exp 0", cmd_valid); end
        n_tests++; if (obs_valid_n - v0 !== 1) begin n_fail++; $display("FAIL good_count: got %0d exp 1", obs_valid_n - v0); end
    endtask

    task automatic test_checksum();
        int v0 = obs_valid_n;
        int e0 = obs_err_n;
        int mv0 = m_valid_n;
        int me0 = m_err_n;
        cyc(1'b1, HDR); cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b1, 8'h03); cyc(1'b1, 8'h06);
        cyc(1'b0, 8'h00);
        n_tests++; if (cmd_addr !== 8'h01 || cmd_data !== 16'h0203) begin n_fail++; $display("FAIL chk_good_vals: got %h/%h exp 01/0203", cmd_addr, cmd_data); end
        cyc(1'b1, HDR); cyc(1'b1, 8'h01); cyc(1'b1, 8'h02); cyc(1'b1, 8'h03); cyc(1'b1, 8'h07);
        cyc(1'b0, 8'h00);
        n_tests++; if (obs_valid_n - v0 !== m_valid_n - mv0) begin n_fail++; $display("FAIL chk_valid_count: got %0d exp %0d", obs_valid_n - v0, m_valid_n - mv0); end
        n_tests++; if (obs_err_n - e0 !== m_err_n - me0) begin n_fail++; $display("FAIL chk_err_count: got %0d exp %0d", obs_err_n - e0, m_err_n - me0); end
        n_tests++; if (cmd_addr !== m_addr || cmd_data !== m_data) begin n_fail++; $display("FAIL chk_hold: got %h/%h exp %h/%h", cmd_addr, cmd_data, m_addr, m_data); end
`ifdef UART_CMD_CHKSUM_EN
        n_tests++; if (obs_err_n - e0 !== 1) begin n_fail++; $display("FAIL chk_bad_err: got %0d exp 1", obs_err_n - e0); end
`endif
    endtask

    task automatic test_garbage();
        int v0 = obs_valid_n;
        int e0 = obs_err_n;
        cyc(1'b1, 8'h00);
        cyc(1'b1, 8'hFF);
        n_tests++; if (obs_valid_n != v0 || obs_err_n != e0 || cmd_busy !== 1'b0) begin
            n_fail++; $display("FAIL garbage_silent: pulses %0d/%0d busy %b exp 0/0/0", obs_valid_n - v0, obs_err_n - e0, cmd_busy);
        end
        mk_frame(8'h10, HDR, 8'h20, 8'hDA);
        foreach (fq[i]) cyc(1'b1, fq[i]);
        n_tests++; if (cmd_addr !== 8'h10 || cmd_data !== 16'hAA20) begin n_fail++; $display("FAIL garbage_frame: got %h/%h exp 10/AA20", cmd_addr, cmd_data); end
        n_tests++; if (obs_valid_n - v0 !== 1) begin n_fail++; $display("FAIL garbage_count: got %0d exp 1", obs_valid_n - v0); end
    endtask

    task automatic test_timeout();
        int e0 = obs_err_n;
        int v0 = obs_valid_n;
        cyc(1'b1, HDR);
        cyc(1'b1, 8'h05);
        repeat (T - 1) cyc(1'b0, 8'h00);
        n_tests++; if (frame_err !== 1'b0 || cmd_busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: err %b busy %b exp 0/1", frame_err, cmd_busy); end
        cyc(1'b0, 8'h00);
        n_tests++; if (frame_err !== 1'b1 || cmd_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_fire: err %b busy %b exp 1/0", frame_err, cmd_busy); end
        cyc(1'b0, 8'h00);
        n_tests++; if (obs_err_n - e0 !== 1 || m_err_n < 1) begin n_fail++; $display("FAIL timeout_count: got %0d exp 1", obs_err_n - e0); end
        e0 = obs_err_n;
        cyc(1'b1, HDR);
        cyc(1'b1, 8'h05);
        repeat (T - 1) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h33);
        n_tests++; if (frame_err !== 1'b0 || cmd_busy !== 1'b1) begin n_fail++; $display("FAIL timeout_byte_wins: err %b busy %b exp 0/1", frame_err, cmd_busy); end
        repeat (3) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h44);
        if (PAYLOAD == 4) cyc(1'b1, chk(8'h05, 8'h33, 8'h44));
        n_tests++; if (cmd_addr !== 8'h05 || cmd_data !== 16'h3344 || cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL timeout_resume: got %h/%h v%b exp 05/3344 v1", cmd_addr, cmd_data, cmd_valid);
        end
        n_tests++; if (obs_err_n != e0 || obs_valid_n - v0 !== 1) begin n_fail++; $display("FAIL timeout_counts: err %0d valid %0d exp 0/1", obs_err_n - e0, obs_valid_n - v0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0 = obs_valid_n;
        int e0 = obs_err_n;
        logic [7:0] a, h, l;
        cyc(1'b1, HDR);
        cyc(1'b1, 8'h07);
        rst_in = 1'b1;
        cyc(1'b0, 8'h00);
        rst_in = 1'b0;
        cyc(1'b1, 8'h11);
        cyc(1'b1, 8'h22);
        cyc(1'b0, 8'h00);
        n_tests++; if (obs_valid_n != v0 || obs_err_n != e0) begin n_fail++; $display("FAIL rstmid_pulses: valid %0d err %0d exp 0/0", obs_valid_n - v0, obs_err_n - e0); end
        n_tests++; if (cmd_addr !== 8'h00 || cmd_data !== 16'h0000 || cmd_busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %h/%h busy %b exp 00/0000/0", cmd_addr, cmd_data, cmd_busy);
        end
        a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
        mk_frame(a, h, l, chk(a, h, l));
        foreach (fq[i]) cyc(1'b1, fq[i]);
        n_tests++; if (cmd_addr !== a || cmd_data !== {h, l} || cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_next: got %h/%h v%b exp %h/%h v1", cmd_addr, cmd_data, cmd_valid, a, {h, l});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, h, l;
        obs_q.delete();
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            a = 8'($urandom); h = 8'($urandom); l = 8'($urandom);
            mk_frame(a, h, l, chk(a, h, l));
            foreach (fq[i]) cyc(1'b1, fq[i]);
        end
        cyc(1'b0, 8'h00);
        n_tests++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d exp %0d (model %0d)", obs_q.size(), 2, exp_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_frame%0d: got %h exp %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_random();
        int v0 = obs_valid_n;
        int e0 = obs_err_n;
        int mv0 = m_valid_n;
        int me0 = m_err_n;
        logic [7:0] a, h, l, c;
        obs_q.delete();
        exp_q.delete();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b1, 8'($urandom_range(0, 255)));
            a = 8'($urandom);
            h = ($urandom_range(0, 4) == 0) ? HDR : 8'($urandom);
            l = 8'($urandom);
            c = chk(a, h, l);
            if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
            mk_frame(a, h, l, c);
            foreach (fq[i]) begin
                int g;
                g = ($urandom_range(0, 11) == 0) ? int'(T) - 2 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 2));
                repeat (g) cyc(1'b0, 8'h00);
                cyc(1'b1, fq[i]);
            end
        end
        repeat (T + 2) cyc(1'b0, 8'h00);
        n_tests++; if (obs_valid_n - v0 !== m_valid_n - mv0) begin n_fail++; $display("FAIL rand_valid_count: got %0d exp %0d", obs_valid_n - v0, m_valid_n - mv0); end
        n_tests++; if (obs_err_n - e0 !== m_err_n - me0) begin n_fail++; $display("FAIL rand_err_count: got %0d exp %0d", obs_err_n - e0, m_err_n - me0); end
        n_tests++; if (cmd_addr !== m_addr || cmd_data !== m_data) begin n_fail++; $display("FAIL rand_final: got %h/%h exp %h/%h", cmd_addr, cmd_data, m_addr, m_data); end
        n_tests++; if (cmd_busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy: got %b exp 0", cmd_busy); end
        n_tests++; if (obs_both != 0) begin n_fail++; $display("FAIL valid_err_overlap: got %0d exp 0", obs_both); end
        n_tests++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rand_queue_len: got %0d exp %0d", obs_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_cmd%0d: got %h exp %h", i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_good_frame();
        test_checksum();
        test_garbage();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
